// File: rtl/sha256_avalon_slave.sv
`default_nettype none
// ============================================================================
// Module   : sha256_avalon_slave
// Purpose  : Avalon-MM register front-end for a SHA-256 core. Holds the
//            16-word message block, hands it to the core, captures the
//            256-bit digest and reports DONE/ERR/OVR status with an irq.
// Revision : 1.0 - initial release
// ============================================================================
module sha256_avalon_slave #(
  parameter int          ADDR_W         = 6,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ID_VALUE       = 32'h5348_4132
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  output logic [31:0]       avs_readdata,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic              avs_waitrequest,
  output logic              irq,
  output logic              core_blk_valid,
  input  logic              core_blk_ready,
  output logic [511:0]      core_blk_data,
  output logic              core_blk_first,
  input  logic              core_dig_valid,
  input  logic [255:0]      core_dig_data
);

  localparam logic [2:0] c_st_idle = 3'd0;
  localparam logic [2:0] c_st_send = 3'd1;
  localparam logic [2:0] c_st_wait = 3'd2;
  localparam logic [2:0] c_st_done = 3'd3;
  localparam logic [2:0] c_st_err  = 3'd4;

  localparam logic [ADDR_W-1:0] c_addr_ctrl   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] c_addr_status = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] c_addr_id     = ADDR_W'(2);
  localparam logic [15:0]       c_timer_last  = 16'(TIMEOUT_CYCLES - 1);

  logic [2:0]  state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [31:0] msg_q [16];
  logic [31:0] msg_d [16];
  logic [31:0] dig_q [8];
  logic [31:0] dig_d [8];
  logic        first_q, first_d;
  logic        ie_q, ie_d;
  logic        blk_first_q, blk_first_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        ovr_q, ovr_d;
  logic [31:0] rdata_q, rdata_d;

  logic w_busy, w_is_msg, w_is_dig, w_wr, w_start, w_abort;

  // Address decode, bus stall and write qualification
  always_comb begin
    w_busy          = (state_q == c_st_send) || (state_q == c_st_wait);
    w_is_msg        = (avs_address[ADDR_W-1:4] == (ADDR_W-4)'(1));
    w_is_dig        = (avs_address[ADDR_W-1:3] == (ADDR_W-3)'(4));
    avs_waitrequest = avs_write && w_is_msg && w_busy;
    w_wr            = avs_write && !avs_waitrequest;
    // ABORT takes priority, so a START in the same write is dropped entirely
    w_abort         = w_wr && (avs_address == c_addr_ctrl) && avs_writedata[2];
    w_start         = w_wr && (avs_address == c_addr_ctrl) && avs_writedata[0] && !avs_writedata[2];
  end

  // Register writes, command FSM, timeout timer and digest capture
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    msg_d       = msg_q;
    dig_d       = dig_q;
    first_d     = first_q;
    ie_d        = ie_q;
    blk_first_d = blk_first_q;
    done_d      = done_q;
    err_d       = err_q;
    ovr_d       = ovr_q;

    if (w_wr && (avs_address == c_addr_ctrl)) begin
      first_d = avs_writedata[1];
      ie_d    = avs_writedata[3];
    end
    if (w_wr && (avs_address == c_addr_status)) begin
      if (avs_writedata[1]) done_d = 1'b0;
      if (avs_writedata[2]) err_d  = 1'b0;
      if (avs_writedata[3]) ovr_d  = 1'b0;
    end
    if (w_wr && w_is_msg) begin
      msg_d[avs_address[3:0]] = avs_writedata;
    end

    case (state_q)
      c_st_idle, c_st_done, c_st_err: begin
        if (w_start) begin
          state_d     = c_st_send;
          done_d      = 1'b0;
          err_d       = 1'b0;
          blk_first_d = avs_writedata[1];
        end
      end
      c_st_send: begin
        if (w_start) ovr_d = 1'b1;
        if (core_blk_ready) begin
          state_d = c_st_wait;
          timer_d = '0;
        end
      end
      c_st_wait: begin
        if (w_start) ovr_d = 1'b1;
        // A digest arriving on the final timeout cycle still counts as success
        if (core_dig_valid) begin
          for (int i = 0; i < 8; i++) dig_d[i] = core_dig_data[255-32*i -: 32];
          done_d  = 1'b1;
          state_d = c_st_done;
        end else if (timer_q == c_timer_last) begin
          err_d   = 1'b1;
          state_d = c_st_err;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      default: state_d = c_st_idle;
    endcase

    if (w_abort) begin
      state_d = c_st_idle;
      timer_d = '0;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end
  end

  // Registered read data mux; holds its value when no read is issued
  always_comb begin
    rdata_d = rdata_q;
    if (avs_read) begin
      rdata_d = '0;
      if (avs_address == c_addr_ctrl)        rdata_d = {28'd0, ie_q, 1'b0, first_q, 1'b0};
      else if (avs_address == c_addr_status) rdata_d = {28'd0, ovr_q, err_q, done_q, w_busy};
      else if (avs_address == c_addr_id)     rdata_d = ID_VALUE;
      else if (w_is_msg)                     rdata_d = msg_q[avs_address[3:0]];
      else if (w_is_dig)                     rdata_d = dig_q[avs_address[2:0]];
    end
  end

  // State registers; reset release is assumed synchronised upstream
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= c_st_idle;
      timer_q     <= '0;
      for (int i = 0; i < 16; i++) msg_q[i] <= '0;
      for (int i = 0; i < 8; i++)  dig_q[i] <= '0;
      first_q     <= 1'b0;
      ie_q        <= 1'b0;
      blk_first_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      ovr_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      msg_q       <= msg_d;
      dig_q       <= dig_d;
      first_q     <= first_d;
      ie_q        <= ie_d;
      blk_first_q <= blk_first_d;
      done_q      <= done_d;
      err_q       <= err_d;
      ovr_q       <= ovr_d;
      rdata_q     <= rdata_d;
    end
  end

  // Output drive; block data comes straight from MSG, which cannot change while busy
  always_comb begin
    core_blk_data = '0;
    for (int i = 0; i < 16; i++) core_blk_data[511-32*i -: 32] = msg_q[i];
    core_blk_valid = (state_q == c_st_send);
    core_blk_first = blk_first_q;
    avs_readdata   = rdata_q;
    irq            = done_q && ie_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_sha256_avalon_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha256_avalon_slave
// Purpose  : Self-checking bench for sha256_avalon_slave. A main instance
//            (long timeout) and a short-timeout instance share all inputs;
//            a bench-side core model answers block handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha256_avalon_slave;

  logic         clk = 1'b0;
  logic         reset;
  logic [5:0]   avs_address;
  logic         avs_read, avs_write;
  logic [31:0]  avs_writedata;
  logic         core_blk_ready, core_dig_valid;
  logic [255:0] core_dig_data;

  logic [31:0]  avs_readdata, to_readdata;
  logic         avs_waitrequest, to_waitrequest;
  logic         irq, to_irq;
  logic         core_blk_valid, to_blk_valid;
  logic [511:0] core_blk_data, to_blk_data;
  logic         core_blk_first, to_blk_first;

  initial forever #5 clk = ~clk;

  sha256_avalon_slave #(.ADDR_W(6), .TIMEOUT_CYCLES(1024), .ID_VALUE(32'h5348_4132)) dut (
    .clk(clk), .reset(reset), .avs_address(avs_address), .avs_read(avs_read),
    .avs_readdata(avs_readdata), .avs_write(avs_write), .avs_writedata(avs_writedata),
    .avs_waitrequest(avs_waitrequest), .irq(irq), .core_blk_valid(core_blk_valid),
    .core_blk_ready(core_blk_ready), .core_blk_data(core_blk_data),
    .core_blk_first(core_blk_first), .core_dig_valid(core_dig_valid),
    .core_dig_data(core_dig_data));

  sha256_avalon_slave #(.ADDR_W(6), .TIMEOUT_CYCLES(16), .ID_VALUE(32'h5348_4132)) dut_to (
    .clk(clk), .reset(reset), .avs_address(avs_address), .avs_read(avs_read),
    .avs_readdata(to_readdata), .avs_write(avs_write), .avs_writedata(avs_writedata),
    .avs_waitrequest(to_waitrequest), .irq(to_irq), .core_blk_valid(to_blk_valid),
    .core_blk_ready(core_blk_ready), .core_blk_data(to_blk_data),
    .core_blk_first(to_blk_first), .core_dig_valid(core_dig_valid),
    .core_dig_data(core_dig_data));

  localparam logic [255:0] c_abc_digest =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;

  int n_cmp = 0;
  int n_bad = 0;
  int last_stalls = 0;
  int cyc = 0;
  int hs_cyc = -1;
  int rises = 0;

  // ---------------- reference model of the register file ----------------
  logic [31:0] msg_m [16];
  logic [31:0] dig_m [8];
  logic        first_m, ie_m;

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) msg_m[i] = '0;
    for (int i = 0; i < 8; i++)  dig_m[i] = '0;
    first_m = 1'b0;
    ie_m    = 1'b0;
  endfunction

  function automatic void model_write(input logic [5:0] a, input logic [31:0] d);
    if (a == 6'd0) begin
      first_m = d[1];
      ie_m    = d[3];
    end else if (a >= 6'd16 && a < 6'd32) begin
      msg_m[a - 6'd16] = d;
    end
  endfunction

  function automatic logic [31:0] model_read(input logic [5:0] a);
    if (a == 6'd0)                 return {28'd0, ie_m, 1'b0, first_m, 1'b0};
    if (a == 6'd2)                 return 32'h5348_4132;
    if (a >= 6'd16 && a < 6'd32)   return msg_m[a - 6'd16];
    if (a >= 6'd32 && a < 6'd40)   return dig_m[a - 6'd32];
    return 32'd0;
  endfunction

  function automatic logic [511:0] model_block();
    logic [511:0] b = '0;
    for (int i = 0; i < 16; i++) b = (b << 32) | 512'(msg_m[i]);
    return b;
  endfunction

  function automatic void model_take_digest(input logic [255:0] d);
    for (int i = 0; i < 8; i++) dig_m[i] = d[255-32*i -: 32];
  endfunction

  // ---------------- core model ----------------
  logic         auto_ready = 1'b0;
  logic         auto_digest = 1'b0;
  int           dig_delay = 64;
  logic [255:0] model_digest = '0;
  int           inject_req = 0;

  initial begin : core_model
    int rdy_cnt;
    int dig_cnt;
    int inject_ack;
    rdy_cnt = 0; dig_cnt = 0; inject_ack = 0;
    core_blk_ready = 1'b0; core_dig_valid = 1'b0; core_dig_data = '0;
    forever begin
      @(posedge clk); #1;
      core_dig_valid = 1'b0;
      if (core_blk_ready) begin
        core_blk_ready = 1'b0;
        if (auto_digest) dig_cnt = dig_delay;
      end else if (auto_ready && core_blk_valid) begin
        rdy_cnt++;
        if (rdy_cnt == 3) begin
          core_blk_ready = 1'b1;
          rdy_cnt = 0;
        end
      end else begin
        rdy_cnt = 0;
      end
      if (dig_cnt > 0) begin
        dig_cnt--;
        if (dig_cnt == 0) begin
          core_dig_valid = 1'b1;
          core_dig_data  = model_digest;
        end
      end
      if (inject_req != inject_ack) begin
        inject_ack     = inject_req;
        core_dig_valid = 1'b1;
        core_dig_data  = model_digest;
      end
    end
  end

  // cycle counter and handshake / valid-rise monitor
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin : monitor
    logic prev_v;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (core_blk_valid && !prev_v) rises++;
      prev_v = core_blk_valid;
      if (to_blk_valid && core_blk_ready) hs_cyc = cyc + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [5:0] a, input logic [31:0] d);
    int st;
    st = 0;
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(negedge clk);
    while (avs_waitrequest && st < 500) begin
      st++;
      @(negedge clk);
    end
    if (st >= 500) begin
      n_cmp++; n_bad++;
      $display("FAIL write_stall_bound: addr 0x%0h stalled %0d cycles, want accepted", a, st);
    end else begin
      model_write(a, d);
    end
    @(posedge clk); #1;
    avs_write = 1'b0;
    last_stalls = st;
  endtask

  task automatic bus_read(input logic [5:0] a, output logic [31:0] d, output logic [31:0] d_to);
    avs_address = a; avs_read = 1'b1;
    @(posedge clk); #1;
    avs_read = 1'b0;
    d = avs_readdata;
    d_to = to_readdata;
  endtask

  task automatic wait_handshake(input string name);
    int n;
    n = 0;
    while (core_blk_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    check(name, 512'(core_blk_valid), 512'(0));
  endtask

  typedef struct {
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] data;
    string       name;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic wr, input logic [5:0] a, input logic [31:0] d, input string n);
    vec_t v;
    v.wr = wr; v.addr = a; v.data = d; v.name = n;
    tbl.push_back(v);
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] rd, rd_to, rnd;
    logic [5:0]  a;
    int          n, seen_cyc, rises0;

    reset = 1'b1; avs_address = '0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    // 1: reset state
    check("rst_irq", 512'(irq), 512'(0));
    check("rst_blk_valid", 512'(core_blk_valid), 512'(0));
    check("rst_waitrequest", 512'(avs_waitrequest), 512'(0));
    check("rst_blk_first", 512'(core_blk_first), 512'(0));

    // register-map table: wr entries are writes, read entries compare to expected data
    add(0, 6'h02, 32'h5348_4132, "id");
    add(0, 6'h01, 32'h0, "status_rst");
    add(0, 6'h00, 32'h0, "ctrl_rst");
    add(0, 6'h10, 32'h0, "msg0_rst");
    add(0, 6'h20, 32'h0, "dig0_rst");
    add(0, 6'h03, 32'h0, "unmapped_03");
    add(1, 6'h00, 32'h0000_000A, "");
    add(0, 6'h00, 32'h0000_000A, "ctrl_first_ie");
    add(1, 6'h00, 32'h0, "");
    add(0, 6'h00, 32'h0, "ctrl_clear");
    add(1, 6'h1F, 32'hDEAD_BEEF, "");
    add(0, 6'h1F, 32'hDEAD_BEEF, "msg15_rw");
    add(1, 6'h27, 32'h1234_5678, "");
    add(0, 6'h27, 32'h0, "dig7_ro");
    add(1, 6'h3F, 32'hFFFF_FFFF, "");
    add(0, 6'h3F, 32'h0, "unmapped_3f");
    add(0, 6'h28, 32'h0, "unmapped_28");
    add(1, 6'h01, 32'h0000_000F, "");
    add(0, 6'h01, 32'h0, "status_w1c_idle");
    add(1, 6'h02, 32'h0, "");
    add(0, 6'h02, 32'h5348_4132, "id_ro");
    foreach (tbl[i]) begin
      if (tbl[i].wr) bus_write(tbl[i].addr, tbl[i].data);
      else begin
        bus_read(tbl[i].addr, rd, rd_to);
        check(tbl[i].name, 512'(rd), 512'(tbl[i].data));
      end
    end

    // randomized register traffic while idle, checked against the model
    for (int i = 0; i < 60; i++) begin
      a = 6'($urandom_range(2, 63));
      if ($urandom_range(0, 1) == 1) bus_write(a, $urandom);
      else begin
        bus_read(a, rd, rd_to);
        check("rand_read", 512'(rd), 512'(model_read(a)));
      end
    end

    // 2: "abc" block
    auto_ready = 1'b1; auto_digest = 1'b1; dig_delay = 64; model_digest = c_abc_digest;
    for (int i = 0; i < 16; i++) begin
      rnd = (i == 0) ? 32'h6162_6380 : ((i == 15) ? 32'h0000_0018 : 32'h0);
      bus_write(6'(16 + i), rnd);
    end
    bus_write(6'h00, 32'h0000_000B);
    check("t2_blk_valid", 512'(core_blk_valid), 512'(1));
    check("t2_blk_w0", 512'(core_blk_data[511:480]), 512'(32'h6162_6380));
    check("t2_blk_data", core_blk_data, model_block());
    check("t2_blk_first", 512'(core_blk_first), 512'(1));
    n = 0;
    while (!irq && n < 300) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    check("t2_irq", 512'(irq), 512'(1));
    model_take_digest(c_abc_digest);
    bus_read(6'h01, rd, rd_to);
    check("t2_status", 512'(rd), 512'(32'h2));
    bus_read(6'h20, rd, rd_to);
    check("t2_h0", 512'(rd), 512'(32'hBA78_16BF));
    bus_read(6'h27, rd, rd_to);
    check("t2_h7", 512'(rd), 512'(32'hF200_15AD));
    bus_write(6'h01, 32'h2);
    check("t2_irq_cleared", 512'(irq), 512'(0));

    // 3: START and MSG write while WAIT
    model_digest = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    rises0 = rises;
    bus_write(6'h00, 32'h1);
    check("t3_blk_first0", 512'(core_blk_first), 512'(0));
    wait_handshake("t3_handshake");
    bus_write(6'h00, 32'h1);
    rnd = $urandom;
    bus_write(6'h15, rnd);
    check("t3_stalled", 512'(last_stalls > 0), 512'(1));
    model_take_digest(model_digest);
    bus_read(6'h01, rd, rd_to);
    check("t3_status_done_ovr", 512'(rd), 512'(32'hA));
    bus_read(6'h15, rd, rd_to);
    check("t3_msg_landed", 512'(rd), 512'(model_read(6'h15)));
    for (int i = 0; i < 8; i++) begin
      bus_read(6'(32 + i), rd, rd_to);
      check("t3_digest", 512'(rd), 512'(model_read(6'(32 + i))));
    end
    check("t3_single_valid", 512'(rises - rises0), 512'(1));
    bus_write(6'h00, 32'h4);
    bus_write(6'h01, 32'hE);

    // 4: timeout on the 16-cycle instance
    auto_digest = 1'b0;
    bus_write(6'h00, 32'h1);
    avs_address = 6'h01; avs_read = 1'b1;
    n = 0;
    @(negedge clk);
    while (!to_readdata[2] && n < 60) begin
      @(negedge clk);
      n++;
    end
    seen_cyc = cyc;
    avs_read = 1'b0;
    @(posedge clk); #1;
    check("t4_err_latency", 512'(seen_cyc - 1 - hs_cyc), 512'(16));
    bus_read(6'h01, rd, rd_to);
    check("t4_status_err", 512'(rd_to), 512'(32'h4));
    check("t4_long_still_busy", 512'(rd), 512'(32'h1));
    bus_write(6'h00, 32'h1);
    check("t4_recover_send", 512'(to_blk_valid), 512'(1));
    bus_read(6'h01, rd, rd_to);
    check("t4_to_status_send", 512'(rd_to), 512'(32'h1));
    check("t4_long_ovr", 512'(rd), 512'(32'h9));
    bus_write(6'h00, 32'h4);
    bus_write(6'h01, 32'hE);

    // 5: ABORT with the core never ready
    auto_ready = 1'b0;
    repeat (2) @(posedge clk); #1;
    for (int i = 0; i < 16; i++) bus_write(6'(16 + i), $urandom);
    bus_write(6'h00, 32'h5);
    check("t5_abort_wins", 512'(core_blk_valid), 512'(0));
    bus_write(6'h00, 32'h1);
    check("t5_send", 512'(core_blk_valid), 512'(1));
    check("t5_blk_data", core_blk_data, model_block());
    repeat (3) @(posedge clk); #1;
    bus_write(6'h00, 32'h4);
    check("t5_abort_valid", 512'(core_blk_valid), 512'(0));
    bus_read(6'h01, rd, rd_to);
    check("t5_status", 512'(rd), 512'(32'h0));
    for (int i = 0; i < 16; i++) begin
      bus_read(6'(16 + i), rd, rd_to);
      check("t5_msg_kept", 512'(rd), 512'(model_read(6'(16 + i))));
    end

    // 6: async reset mid-WAIT, then a stray digest strobe
    auto_ready = 1'b1; auto_digest = 1'b0;
    model_digest = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom} | 256'h1;
    bus_write(6'h00, 32'h1);
    wait_handshake("t6_handshake");
    #3 reset = 1'b1;
    #1 check("t6_valid_async", 512'(core_blk_valid), 512'(0));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    model_reset();
    inject_req++;
    repeat (4) @(posedge clk); #1;
    bus_read(6'h01, rd, rd_to);
    check("t6_status", 512'(rd), 512'(32'h0));
    bus_read(6'h20, rd, rd_to);
    check("t6_h0", 512'(rd), 512'(model_read(6'h20)));
    bus_read(6'h27, rd, rd_to);
    check("t6_h7", 512'(rd), 512'(model_read(6'h27)));
    bus_read(6'h10, rd, rd_to);
    check("t6_msg0", 512'(rd), 512'(model_read(6'h10)));
    check("t6_blk_valid", 512'(core_blk_valid), 512'(0));
    check("t6_irq", 512'(irq), 512'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
